// File: rtl/pixel_frame_tracker_pkg.sv
// Shared types and sizing helpers for the pixel frame tracker.
// Holds the tracker FSM state encoding, the default raster geometry
// and the coordinate-width helper used to size x/y counters.
package pixel_frame_tracker_pkg;

    // Default raster geometry (1080p active area).
    localparam int img_width_bmp  = 1920;
    localparam int img_height_bmp = 1080;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } tracker_state_t;

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int coord_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int x_w_default = coord_w(img_width_bmp);
    localparam int y_w_default = coord_w(img_height_bmp);

endpackage

// File: rtl/pixel_frame_tracker_if.sv
// Pixel stream tap: qualifier plus packed pixel (channel 0 in the MSBs).
// Ports: valid (pixel qualifier), pix_data (DATA_W packed pixel).
// master drives the stream, slave observes it.
interface pixel_frame_tracker_if #(
    parameter int DATA_W = 24
);
    logic              valid;
    logic [DATA_W-1:0] pix_data;

    modport master (output valid, output pix_data);
    modport slave  (input  valid, input  pix_data);
endinterface

// File: rtl/pixel_frame_tracker_channel_accum.sv
// Single-channel frame checksum: running sum modulo 2^SUM_W of accepted samples.
// Ports: pixclk/reset, add (accumulate din), clear (zero running sum),
// load (publish running sum including din to sum_o and restart from zero).
module pixel_channel_accum #(
    parameter int CH_W  = 8,
    parameter int SUM_W = 32
) (
    input  logic             pixclk,
    input  logic             reset,
    input  logic             add,
    input  logic             clear,
    input  logic             load,
    input  logic [CH_W-1:0]  din,
    output logic [SUM_W-1:0] sum_o
);

    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_inc;

    // Sum including the sample being accepted this cycle, so a load on
    // the final pixel publishes a complete frame total.
    always_comb begin
        acc_inc = acc_q;
        if (add) begin
            acc_inc = acc_q + SUM_W'(din);
        end
    end

    always_ff @(posedge pixclk) begin
        if (!reset) begin
            acc_q <= '0;
            sum_o <= '0;
        end else begin
            if (load) begin
                sum_o <= acc_inc;
            end
            // Clearing on load lets a back-to-back pixel open the next
            // frame's sum from zero.
            if (load || clear) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_inc;
            end
        end
    end

endmodule

// File: rtl/pixel_frame_tracker.sv
// Raster position tracker: registers the pixel tap, labels each accepted pixel
// with x/y, pulses line/frame done, counts frames and publishes per-channel sums.
// Ports: pixclk/reset, pix_in (valid + pix_data), restart; pix_valid_o/pix_data_o,
// x_coord/y_coord, line_done, frame_done, frame_cnt, sum_valid, frame_sum, done,
// err_overrun. One cycle input-to-output latency; no backpressure (pure monitor).
module pixel_frame_tracker
    import pixel_frame_tracker_pkg::*;
#(
    parameter  int IMG_W      = img_width_bmp,
    parameter  int IMG_H      = img_height_bmp,
    parameter  int NUM_CH     = 3,
    parameter  int CH_W       = 8,
    parameter  int SUM_W      = 32,
    parameter  int CONTINUOUS = 0,
    localparam int X_W        = coord_w(IMG_W),
    localparam int Y_W        = coord_w(IMG_H),
    localparam int PIX_W      = NUM_CH * CH_W
) (
    input  logic                    pixclk,
    input  logic                    reset,
    pixel_frame_tracker_if.slave    pix_in,
    input  logic                    restart,
    output logic                    pix_valid_o,
    output logic [PIX_W-1:0]        pix_data_o,
    output logic [X_W-1:0]          x_coord,
    output logic [Y_W-1:0]          y_coord,
    output logic                    line_done,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt,
    output logic                    sum_valid,
    output logic [NUM_CH*SUM_W-1:0] frame_sum,
    output logic                    done,
    output logic                    err_overrun
);

    localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

    tracker_state_t   state_q, state_d;

    logic             d_valid;
    logic [PIX_W-1:0] d_data;

    logic [X_W-1:0]   x_q, x_hold_q;
    logic [Y_W-1:0]   y_q, y_hold_q;

    logic             accept;
    logic             x_last;
    logic             y_last;
    logic             frame_end;
    logic             restart_ok;

    assign accept     = d_valid && (state_q != DONE);
    assign x_last     = (x_q == X_MAX);
    assign y_last     = (y_q == Y_MAX);
    assign frame_end  = accept && x_last && y_last;
    assign restart_ok = (CONTINUOUS == 0) && restart && (state_q == DONE);

    // ---------------- FSM ----------------
    always_ff @(posedge pixclk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_end && (CONTINUOUS == 0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (restart_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Input stage, counters, flags ----------------
    always_ff @(posedge pixclk) begin
        if (!reset) begin
            d_valid     <= 1'b0;
            d_data      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            x_hold_q    <= '0;
            y_hold_q    <= '0;
            frame_cnt   <= '0;
            sum_valid   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            d_valid   <= pix_in.valid;
            d_data    <= pix_in.pix_data;
            // frame_sum is registered on the final pixel, so its strobe
            // trails frame_done by one cycle.
            sum_valid <= frame_end;

            if (accept) begin
                x_hold_q <= x_q;
                y_hold_q <= y_q;
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_last ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end

            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            // Any pixel arriving while parked in DONE is dropped and flagged,
            // including one that coincides with restart.
            if ((state_q == DONE) && d_valid) begin
                err_overrun <= 1'b1;
            end
        end
    end

    // ---------------- Outputs ----------------
    // Coordinates show the live counters on an accepted pixel and otherwise
    // hold the last accepted position.
    assign pix_valid_o = accept;
    assign pix_data_o  = accept ? d_data : '0;
    assign x_coord     = accept ? x_q : x_hold_q;
    assign y_coord     = accept ? y_q : y_hold_q;
    assign line_done   = accept && x_last;
    assign frame_done  = frame_end;
    assign done        = (state_q == DONE);

    // ---------------- Per-channel checksums ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pixel_channel_accum #(
            .CH_W  (CH_W),
            .SUM_W (SUM_W)
        ) u_accum (
            .pixclk (pixclk),
            .reset  (reset),
            .add    (accept),
            .clear  (restart_ok),
            .load   (frame_end),
            .din    (d_data[(NUM_CH-1-c)*CH_W +: CH_W]),
            .sum_o  (frame_sum[(NUM_CH-1-c)*SUM_W +: SUM_W])
        );
    end

endmodule
